led_matrix_pwm: RTL and testbench

Parametrised row/column multiplexer for the on-board LED matrix: scans ROWS×COLS LEDs one at a time and applies global PWM brightness. Frame updates are double-buffered so pattern changes never tear mid-scan. It sits between fabric logic producing an LED bitmap and the anode pins (`aled`) and the cathode tri-state enables (`kled_tri`), which feed SB_IO cells whose output is tied high.

---
 rtl/led_matrix_pwm_if.sv | 24 ++
 rtl/led_matrix_pwm.sv | 106 ++++++++++
 tb/tb_led_matrix_pwm.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_matrix_pwm_if.sv
// Bitmap/brightness inputs and LED pin outputs of the LED matrix scanner.
// master = fabric logic producing the frame, slave = the scanner itself.
interface led_matrix_pwm_if #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int PWM_BITS = 4
);
    logic [ROWS*COLS-1:0] ledbits;
    logic                 load;
    logic [PWM_BITS-1:0]  bright;
    logic [COLS-1:0]      aled;
    logic [ROWS-1:0]      kled_tri;
    logic                 frame_start;

    modport master (
        output ledbits, load, bright,
        input  aled, kled_tri, frame_start
    );

    modport slave (
        input  ledbits, load, bright,
        output aled, kled_tri, frame_start
    );
endinterface

// File: rtl/led_matrix_pwm.sv
// Row/column LED matrix scanner with global PWM brightness and a double-buffered frame.
// Optional macro LED_MATRIX_BLANK_EN forces the first two clocks of every slot dark.
module led_matrix_pwm #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int PRESCALE_LOG2 = 5,
    parameter int PWM_BITS      = 4
) (
    input logic               clk,
    input logic               rst,
    led_matrix_pwm_if.slave   bus
);
    localparam int NSLOT = ROWS * COLS;
    localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    logic [PRESCALE_LOG2-1:0] p_q, p_d;
    logic [SW-1:0]            s_q, s_d;
    logic [NSLOT-1:0]         shadow_q, shadow_d;
    logic [NSLOT-1:0]         display_q, display_d;
    logic [PWM_BITS-1:0]      bright_q, bright_d;
    logic [COLS-1:0]          aled_q, aled_d;
    logic [ROWS-1:0]          kled_q, kled_d;
    logic                     pend_q, pend_d;
    logic                     fs_q, fs_d;

    logic                     p_last, s_last, wrap, slot_start, lit;
    logic [PWM_BITS-1:0]      bright_eff;

    // All-ones brightness is a constant-on level rather than a 15/16 duty.
    function automatic logic pwm_on(input logic [PWM_BITS-1:0] phase,
                                    input logic [PWM_BITS-1:0] level);
        return (level == {PWM_BITS{1'b1}}) || (phase < level);
    endfunction

    always_comb begin
        p_last     = (p_q == {PRESCALE_LOG2{1'b1}});
        s_last     = (s_q == SW'(NSLOT - 1));
        wrap       = p_last && s_last;
        slot_start = (p_q == '0);

        p_d = p_q + PRESCALE_LOG2'(1);
        s_d = s_q;
        if (p_last) begin
            s_d = s_last ? '0 : s_q + SW'(1);
        end

        shadow_d = bus.load ? bus.ledbits : shadow_q;
        // A load coinciding with the frame wrap goes straight to the display.
        display_d = display_q;
        if (wrap) begin
            display_d = bus.load ? bus.ledbits : shadow_q;
        end

        // The level sampled at p=0 governs the whole slot, including p=0 itself.
        bright_d   = slot_start ? bus.bright : bright_q;
        bright_eff = bright_d;

        lit = display_q[s_q] && pwm_on(p_q[PRESCALE_LOG2-1 -: PWM_BITS], bright_eff);
`ifdef LED_MATRIX_BLANK_EN
        if (int'(p_q) < 2) begin
            lit = 1'b0;
        end
`endif

        aled_d = {COLS{1'b1}};
        kled_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (lit && (int'(s_q) / COLS == r)) kled_d[r] = 1'b1;
        end
        for (int c = 0; c < COLS; c++) begin
            if (lit && (int'(s_q) % COLS == c)) aled_d[c] = 1'b0;
        end

        // Delay by one so the pulse lines up with slot 0's registered outputs.
        pend_d = wrap;
        fs_d   = pend_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q       <= '0;
            s_q       <= '0;
            shadow_q  <= '0;
            display_q <= '0;
            bright_q  <= '0;
            aled_q    <= {COLS{1'b1}};
            kled_q    <= '0;
            pend_q    <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            p_q       <= p_d;
            s_q       <= s_d;
            shadow_q  <= shadow_d;
            display_q <= display_d;
            bright_q  <= bright_d;
            aled_q    <= aled_d;
            kled_q    <= kled_d;
            pend_q    <= pend_d;
            fs_q      <= fs_d;
        end
    end

    assign bus.aled        = aled_q;
    assign bus.kled_tri    = kled_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_led_matrix_pwm.sv
// Directed bench for led_matrix_pwm with default parameters (4x4, 32-clock slots, 4-bit PWM).
module tb_led_matrix_pwm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    logic [3:0] kled_a [512];
    logic [3:0] aled_a [512];
    logic       fs_a   [512];
    int         lit_cnt, first_k, last_k, bad_cnt, fs_cnt;

    led_matrix_pwm_if #(.ROWS(4), .COLS(4), .PWM_BITS(4)) bus ();

    led_matrix_pwm #(.ROWS(4), .COLS(4), .PRESCALE_LOG2(5), .PWM_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] bits);
        bus.ledbits = bits;
        bus.load    = 1'b1;
        tick();
        bus.load    = 1'b0;
    endtask

    task automatic wait_fs(output bit found);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.frame_start !== 1'b1 && n < 1200);
        found = (bus.frame_start === 1'b1);
    endtask

    // Records the 512 output cycles of the next frame, k=0 being the frame_start cycle.
    task automatic capture_frame(input string name);
        bit found;
        wait_fs(found);
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL %s_frame_start: got none, expected a pulse within 1200 clocks", name);
        end
        lit_cnt = 0; first_k = -1; last_k = -1; bad_cnt = 0; fs_cnt = 0;
        for (int k = 0; k < 512; k++) begin
            kled_a[k] = bus.kled_tri;
            aled_a[k] = bus.aled;
            fs_a[k]   = bus.frame_start;
            if (bus.frame_start === 1'b1) fs_cnt++;
            if (bus.kled_tri !== 4'b0000) begin
                lit_cnt++;
                if (first_k < 0) first_k = k;
                last_k = k;
                if (!$onehot(bus.kled_tri) || !$onehot(~bus.aled)) bad_cnt++;
            end else if (bus.aled !== 4'b1111) begin
                bad_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int  n;
        int  lit;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.aled !== 4'b1111) begin fails++; $display("FAIL rst_aled: got %b expected 1111", bus.aled); end
        checks++;
        if (bus.kled_tri !== 4'b0000) begin fails++; $display("FAIL rst_kled: got %b expected 0000", bus.kled_tri); end
        checks++;
        if (bus.frame_start !== 1'b0) begin fails++; $display("FAIL rst_fs: got %b expected 0", bus.frame_start); end

        rst = 1'b0;
        bus.ledbits = 16'hFFFF;
        bus.load    = 1'b1;
        bus.bright  = 4'hF;
        n = 0; lit = 0;
        tick();
        n++;
        bus.load = 1'b0;
        if (bus.kled_tri !== 4'b0000) lit++;
        while (bus.frame_start !== 1'b1 && n < 600) begin
            tick();
            n++;
            if (bus.frame_start !== 1'b1 && bus.kled_tri !== 4'b0000) lit++;
        end
        checks++;
        if (n !== 513) begin fails++; $display("FAIL first_fs_edge: got %0d expected 513", n); end
        checks++;
        if (lit !== 0) begin fails++; $display("FAIL first_frame_dark: got %0d lit cycles expected 0", lit); end
        checks++;
        if (bus.kled_tri !== 4'b0001) begin fails++; $display("FAIL frame1_k0_kled: got %b expected 0001", bus.kled_tri); end

        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (bus.kled_tri !== 4'b0001) begin fails++; $display("FAIL frame1_k40_kled: got %b expected 0001", bus.kled_tri); end
        checks++;
        if (bus.aled !== 4'b1101) begin fails++; $display("FAIL frame1_k40_aled: got %b expected 1101", bus.aled); end

        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.aled !== 4'b1111 || bus.kled_tri !== 4'b0000 || bus.frame_start !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: got aled=%b kled=%b fs=%b expected 1111/0000/0", bus.aled, bus.kled_tri, bus.frame_start);
        end
        tick();
        checks++;
        if (bus.aled !== 4'b1111 || bus.kled_tri !== 4'b0000 || bus.frame_start !== 1'b0) begin
            fails++;
            $display("FAIL held_rst: got aled=%b kled=%b fs=%b expected 1111/0000/0", bus.aled, bus.kled_tri, bus.frame_start);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_led();
        bus.bright = 4'hF;
        strobe(16'h0020);
        capture_frame("single");
        checks++;
        if (lit_cnt !== 32) begin fails++; $display("FAIL single_lit: got %0d expected 32", lit_cnt); end
        checks++;
        if (first_k !== 160 || last_k !== 191) begin fails++; $display("FAIL single_window: got %0d..%0d expected 160..191", first_k, last_k); end
        checks++;
        if (kled_a[160] !== 4'b0010 || aled_a[160] !== 4'b1101) begin
            fails++; $display("FAIL single_pins: got kled=%b aled=%b expected 0010/1101", kled_a[160], aled_a[160]);
        end
        checks++;
        if (bad_cnt !== 0) begin fails++; $display("FAIL single_encoding: got %0d bad cycles expected 0", bad_cnt); end
        checks++;
        if (fs_cnt !== 1 || fs_a[0] !== 1'b1) begin fails++; $display("FAIL single_fs_count: got %0d expected 1", fs_cnt); end
    endtask

    task automatic test_pwm();
        bus.bright = 4'd4;
        strobe(16'hFFFF);
        capture_frame("pwm4");
        checks++;
        if (lit_cnt !== 128) begin fails++; $display("FAIL pwm4_lit: got %0d expected 128", lit_cnt); end
        checks++;
        if (kled_a[7] !== 4'b0001 || aled_a[7] !== 4'b1110) begin
            fails++; $display("FAIL pwm4_k7: got kled=%b aled=%b expected 0001/1110", kled_a[7], aled_a[7]);
        end
        checks++;
        if (kled_a[8] !== 4'b0000 || aled_a[8] !== 4'b1111) begin
            fails++; $display("FAIL pwm4_k8: got kled=%b aled=%b expected 0000/1111", kled_a[8], aled_a[8]);
        end
        checks++;
        if (kled_a[195] !== 4'b0010 || aled_a[195] !== 4'b1011) begin
            fails++; $display("FAIL pwm4_slot6: got kled=%b aled=%b expected 0010/1011", kled_a[195], aled_a[195]);
        end
        checks++;
        if (bad_cnt !== 0) begin fails++; $display("FAIL pwm4_encoding: got %0d bad cycles expected 0", bad_cnt); end

        bus.bright = 4'd0;
        capture_frame("pwm0");
        checks++;
        if (lit_cnt !== 0) begin fails++; $display("FAIL pwm0_lit: got %0d expected 0", lit_cnt); end
    endtask

    task automatic test_double_buffer();
        bus.bright = 4'hF;
        strobe(16'h0001);
        for (int i = 0; i < 5; i++) tick();
        strobe(16'h8000);
        capture_frame("dbuf");
        checks++;
        if (lit_cnt !== 32) begin fails++; $display("FAIL dbuf_lit: got %0d expected 32", lit_cnt); end
        checks++;
        if (first_k !== 480) begin fails++; $display("FAIL dbuf_first: got %0d expected 480", first_k); end
        checks++;
        if (kled_a[480] !== 4'b1000 || aled_a[480] !== 4'b0111) begin
            fails++; $display("FAIL dbuf_slot15: got kled=%b aled=%b expected 1000/0111", kled_a[480], aled_a[480]);
        end
        checks++;
        if (kled_a[0] !== 4'b0000) begin fails++; $display("FAIL dbuf_slot0: got %b expected 0000", kled_a[0]); end
    endtask

    task automatic test_bypass();
        bit found;
        wait_fs(found);
        checks++;
        if (!found) begin fails++; $display("FAIL bypass_sync: got no frame_start expected one"); end
        for (int i = 0; i < 510; i++) tick();
        bus.ledbits = 16'h0001;
        bus.load    = 1'b1;
        tick();
        bus.load    = 1'b0;
        checks++;
        if (bus.kled_tri !== 4'b1000) begin fails++; $display("FAIL bypass_old_slot15: got %b expected 1000", bus.kled_tri); end
        tick();
        checks++;
        if (bus.frame_start !== 1'b1) begin fails++; $display("FAIL bypass_fs: got %b expected 1", bus.frame_start); end
        checks++;
        if (bus.kled_tri !== 4'b0001 || bus.aled !== 4'b1110) begin
            fails++; $display("FAIL bypass_slot0: got kled=%b aled=%b expected 0001/1110", bus.kled_tri, bus.aled);
        end
    endtask

    task automatic test_blank_full();
        bus.bright = 4'hF;
        strobe(16'hFFFF);
        capture_frame("full");
`ifdef LED_MATRIX_BLANK_EN
        checks++;
        if (lit_cnt !== 480) begin fails++; $display("FAIL blank_lit: got %0d expected 480", lit_cnt); end
        checks++;
        if (kled_a[0] !== 4'b0000 || kled_a[1] !== 4'b0000 || kled_a[33] !== 4'b0000) begin
            fails++; $display("FAIL blank_gap: got %b %b %b expected 0000", kled_a[0], kled_a[1], kled_a[33]);
        end
        checks++;
        if (kled_a[2] !== 4'b0001 || kled_a[34] !== 4'b0001) begin
            fails++; $display("FAIL blank_on: got %b %b expected 0001", kled_a[2], kled_a[34]);
        end
`else
        checks++;
        if (lit_cnt !== 512) begin fails++; $display("FAIL full_lit: got %0d expected 512", lit_cnt); end
        checks++;
        if (kled_a[0] !== 4'b0001 || kled_a[1] !== 4'b0001 || kled_a[34] !== 4'b0001) begin
            fails++; $display("FAIL full_on: got %b %b %b expected 0001", kled_a[0], kled_a[1], kled_a[34]);
        end
`endif
        checks++;
        if (kled_a[511] !== 4'b1000 || aled_a[511] !== 4'b0111) begin
            fails++; $display("FAIL full_slot15: got kled=%b aled=%b expected 1000/0111", kled_a[511], aled_a[511]);
        end
        checks++;
        if (bad_cnt !== 0) begin fails++; $display("FAIL full_encoding: got %0d bad cycles expected 0", bad_cnt); end
    endtask

    initial begin
        bus.ledbits = '0;
        bus.load    = 1'b0;
        bus.bright  = '0;
        test_reset();
        test_single_led();
        test_pwm();
        test_double_buffer();
        test_bypass();
        test_blank_full();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
